// File: rtl/rr_packet_scheduler_pkg.sv
// Shared encodings for the round-robin packet scheduler: FSM states and requester indices.
package rr_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  localparam logic REQ1 = 1'b0;
  localparam logic REQ2 = 1'b1;

endpackage

// File: rtl/rr_packet_scheduler_output_stage_reg.sv
// Single-entry valid/ready output register carrying {data, last, choice}.
module rr_packet_scheduler_output_stage_reg
  import rr_packet_scheduler_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              in_ready,
  input  logic [DATA_W+1:0] beat_p0,
  output logic [DATA_W+1:0] beat_p1,
  output logic              vld_p1,
  output logic              slot_free
);

  assign slot_free = !vld_p1 || in_ready;

  // Stage p0 -> p1: refill on load, otherwise drain when downstream takes the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      beat_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      beat_p1 <= beat_p0;
    end else if (in_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_packet_scheduler.sv
// Two-requester, packet-atomic round-robin scheduler feeding one registered output stage,
// with a lock timeout that frees the stage from an owner that goes silent mid-packet.
module rr_packet_scheduler
  import rr_packet_scheduler_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_last_1,
  output logic              out_stall_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_last_2,
  output logic              out_stall_2,
  input  logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_choice,
  output logic              out_timeout
);

  localparam int              CNT_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t            state, state_n;
  logic              ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              timeout_n;
  logic              sel, sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              slot_free, accept;
  logic [DATA_W+1:0] beat_p0, beat_p1;

  // Stage p0: pick a requester; ownership pins the choice until the packet ends.
  always_comb begin
    sel = REQ1;
    case (state)
      OWN1:    sel = REQ1;
      OWN2:    sel = REQ2;
      default: begin
        if (in_valid_1 && in_valid_2) sel = ptr;
        else if (in_valid_2)          sel = REQ2;
      end
    endcase
  end

  assign sel_valid = (sel == REQ2) ? in_valid_2 : in_valid_1;
  assign sel_last  = (sel == REQ2) ? in_last_2  : in_last_1;
  assign sel_data  = (sel == REQ2) ? in_data_2  : in_data_1;

  // Gating with reset keeps both stalls high while reset is held.
  assign accept      = reset && slot_free && sel_valid;
  assign out_stall_1 = !(accept && sel == REQ1);
  assign out_stall_2 = !(accept && sel == REQ2);
  assign beat_p0     = {sel_data, sel_last, sel};

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n = '0;
          if (sel_last) ptr_n   = ~sel;
          else          state_n = (sel == REQ2) ? OWN2 : OWN1;
        end
      end
      OWN1, OWN2: begin
        if (accept) begin
          cnt_n = '0;
          if (sel_last) begin
            state_n = IDLE;
            ptr_n   = ~sel;
          end
        end else if (!sel_valid) begin
          // Downstream-only stalls leave the counter alone; only owner silence counts.
          if (cnt >= CNT_LAST) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
            ptr_n     = ~sel;
            cnt_n     = '0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= REQ1;
      cnt         <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      out_timeout <= timeout_n;
    end
  end

  // Stage p1: registered output beat.
  rr_packet_scheduler_output_stage_reg #(
    .DATA_W (DATA_W)
  ) output_stage_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .in_ready  (in_ready),
    .beat_p0   (beat_p0),
    .beat_p1   (beat_p1),
    .vld_p1    (out_valid),
    .slot_free (slot_free)
  );

  assign out_data   = beat_p1[DATA_W+1:2];
  assign out_last   = beat_p1[1];
  assign out_choice = beat_p1[0];

endmodule

// File: tb/tb_rr_packet_scheduler.sv
// Directed bench for rr_packet_scheduler with LOCK_TIMEOUT=4.
module tb_rr_packet_scheduler;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              in_valid_1, in_last_1, out_stall_1;
  logic [DATA_W-1:0] in_data_1;
  logic              in_valid_2, in_last_2, out_stall_2;
  logic [DATA_W-1:0] in_data_2;
  logic              in_ready;
  logic              out_valid, out_last, out_choice, out_timeout;
  logic [DATA_W-1:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  rr_packet_scheduler #(
    .DATA_W       (DATA_W),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_1  (in_valid_1),
    .in_data_1   (in_data_1),
    .in_last_1   (in_last_1),
    .out_stall_1 (out_stall_1),
    .in_valid_2  (in_valid_2),
    .in_data_2   (in_data_2),
    .in_last_2   (in_last_2),
    .out_stall_2 (out_stall_2),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_choice  (out_choice),
    .out_timeout (out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic c);
    chk({tag, "_valid"},  out_valid,  v);
    chk({tag, "_data"},   out_data,   d);
    chk({tag, "_last"},   out_last,   l);
    chk({tag, "_choice"}, out_choice, c);
  endtask

  initial begin
    reset = 1'b0;
    in_valid_1 = 1'b1; in_data_1 = 32'h0; in_last_1 = 1'b1;
    in_valid_2 = 1'b1; in_data_2 = 32'h0; in_last_2 = 1'b1;
    in_ready = 1'b1;

    // Reset state: registers cleared, both stalls high.
    #3;
    chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_timeout", out_timeout, 1'b0);
    chk("rst_stall_1", out_stall_1, 1'b1);
    chk("rst_stall_2", out_stall_2, 1'b1);
    step();
    step();
    reset = 1'b1;

    // Single 1-beat packet from requester 1.
    in_valid_1 = 1'b1; in_data_1 = 32'h11; in_last_1 = 1'b1;
    in_valid_2 = 1'b0;
    #1;
    chk("t1_stall_1", out_stall_1, 1'b0);
    chk("t1_stall_2", out_stall_2, 1'b1);
    step();
    chk_out("t1_out", 1'b1, 32'h11, 1'b1, 1'b0);

    // Requester 2 alone returns the pointer to requester 1.
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b1; in_data_2 = 32'h22; in_last_2 = 1'b1;
    #1;
    chk("t1b_stall_2", out_stall_2, 1'b0);
    step();
    chk_out("t1b_out", 1'b1, 32'h22, 1'b1, 1'b1);

    // Both requesters contend with 1-beat packets: strict alternation starting at 0.
    for (int i = 0; i < 5; i++) begin
      in_valid_1 = 1'b1; in_data_1 = 32'h100 + i; in_last_1 = 1'b1;
      in_valid_2 = 1'b1; in_data_2 = 32'h200 + i; in_last_2 = 1'b1;
      #1;
      chk($sformatf("alt%0d_stall_1", i), out_stall_1, (i % 2 == 1));
      chk($sformatf("alt%0d_stall_2", i), out_stall_2, (i % 2 == 0));
      step();
      chk_out($sformatf("alt%0d", i), 1'b1,
              (i % 2 == 0) ? 32'h100 + i : 32'h200 + i, 1'b1, (i % 2 == 1));
    end

    // Requester 2 three-beat packet holds the stage against requester 1.
    in_valid_1 = 1'b1; in_data_1 = 32'h300; in_last_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_2 = 1'b1; in_data_2 = 32'h400 + k; in_last_2 = (k == 2);
      #1;
      chk($sformatf("pkt%0d_stall_1", k), out_stall_1, 1'b1);
      chk($sformatf("pkt%0d_stall_2", k), out_stall_2, 1'b0);
      step();
      chk_out($sformatf("pkt%0d", k), 1'b1, 32'h400 + k, (k == 2), 1'b1);
    end
    in_data_2 = 32'h500; in_last_2 = 1'b1;
    #1;
    chk("after_pkt_stall_1", out_stall_1, 1'b0);
    chk("after_pkt_stall_2", out_stall_2, 1'b1);
    step();
    chk_out("after_pkt", 1'b1, 32'h300, 1'b1, 1'b0);

    // Downstream backpressure: output holds, both stall, pointer unchanged.
    in_ready = 1'b0;
    in_data_1 = 32'h301;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_stall_1", k), out_stall_1, 1'b1);
      chk($sformatf("bp%0d_stall_2", k), out_stall_2, 1'b1);
      step();
      chk_out($sformatf("bp%0d", k), 1'b1, 32'h300, 1'b1, 1'b0);
    end
    in_ready = 1'b1;
    #1;
    chk("bp_rel_stall_1", out_stall_1, 1'b1);
    chk("bp_rel_stall_2", out_stall_2, 1'b0);
    step();
    chk_out("bp_rel", 1'b1, 32'h500, 1'b1, 1'b1);

    // Lock timeout: requester 1 starts a packet then goes silent.
    in_valid_1 = 1'b1; in_data_1 = 32'h600; in_last_1 = 1'b0;
    in_valid_2 = 1'b1; in_data_2 = 32'h700; in_last_2 = 1'b1;
    #1;
    chk("to_start_stall_1", out_stall_1, 1'b0);
    step();
    chk_out("to_start", 1'b1, 32'h600, 1'b0, 1'b0);
    in_valid_1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("to_wait%0d_timeout", k), out_timeout, 1'b0);
      chk($sformatf("to_wait%0d_stall_2", k), out_stall_2, 1'b1);
      step();
    end
    chk("to_wait4_timeout", out_timeout, 1'b0);
    chk("to_drained_valid", out_valid, 1'b0);
    step();
    chk("to_fire_timeout", out_timeout, 1'b1);
    chk("to_fire_stall_2", out_stall_2, 1'b0);
    step();
    chk("to_after_timeout", out_timeout, 1'b0);
    chk_out("to_after", 1'b1, 32'h700, 1'b1, 1'b1);

    // Reset mid-packet: pointer first made to favour requester 2.
    in_valid_1 = 1'b1; in_data_1 = 32'h801; in_last_1 = 1'b1;
    in_valid_2 = 1'b0;
    step();
    chk_out("pre_rst", 1'b1, 32'h801, 1'b1, 1'b0);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b1; in_data_2 = 32'h810; in_last_2 = 1'b0;
    step();
    in_data_2 = 32'h811;
    step();
    chk_out("mid_pkt", 1'b1, 32'h811, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_stall_1", out_stall_1, 1'b1);
    chk("mid_rst_stall_2", out_stall_2, 1'b1);
    step();
    reset = 1'b1;
    in_valid_1 = 1'b1; in_data_1 = 32'h900; in_last_1 = 1'b1;
    in_valid_2 = 1'b1; in_data_2 = 32'h902; in_last_2 = 1'b1;
    #1;
    chk("post_rst_stall_1", out_stall_1, 1'b0);
    chk("post_rst_stall_2", out_stall_2, 1'b1);
    step();
    chk_out("post_rst", 1'b1, 32'h900, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
